// File: rtl/unidade_pc_pkg.sv
// ---------------------------------------------------------------------------
// unidade_pc_pkg
// Shared constants for the program-counter unit with return stack:
//   - pc_control encodings (3-bit next-PC mode select)
//   - width of the absolute jump/call field
// ---------------------------------------------------------------------------
package unidade_pc_pkg;

    localparam int JUMP_W = 26;

    localparam logic [2:0] PC_SEQ    = 3'b000;
    localparam logic [2:0] PC_JUMP   = 3'b001;
    localparam logic [2:0] PC_REG    = 3'b010;
    localparam logic [2:0] PC_BRANCH = 3'b011;
    localparam logic [2:0] PC_CALL   = 3'b100;
    localparam logic [2:0] PC_RET    = 3'b101;
    localparam logic [2:0] PC_HOLD   = 3'b110;

endpackage

// File: rtl/pilha_retorno.sv
// ---------------------------------------------------------------------------
// pilha_retorno
// LIFO return-address stack. A push while full wraps the pointer and
// overwrites the oldest entry; a pop while empty is ignored.
// Ports:
//   clk, rst        clock, synchronous active-high reset (pointer/count only)
//   push, pop       one-cycle strobes, never both asserted together
//   din             address to push
//   dout            current top-of-stack entry (combinational read)
//   count           number of valid entries, 0..STACK_DEPTH
// ---------------------------------------------------------------------------
module pilha_retorno #(
    parameter  int ADDR_W      = 32,
    parameter  int STACK_DEPTH = 8,
    localparam int PTR_W       = $clog2(STACK_DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [PTR_W-1:0]  ptr;    // next free slot; top entry sits at ptr-1

    assign dout = mem[ptr - PTR_W'(1)];

    // NOTE: the storage array has no reset; only pointer and count are
    // cleared, which keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[ptr] <= din;
    end

    // NOTE: all sequential state is assigned with <= so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            // Power-of-two depth: pointer wraps onto the oldest entry when full.
            ptr <= ptr + PTR_W'(1);
            if (count != CNT_FULL)
                count <= count + CNT_W'(1);
        end else if (pop && count != '0) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/unidade_pc_pilha.sv
// ---------------------------------------------------------------------------
// unidade_pc_pilha
// Program-counter unit with a hardware return stack for call/return.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              advance enable (pc and stack hold when low)
//   pc_control      next-PC mode (see unidade_pc_pkg)
//   jump_address    26-bit absolute jump/call field (word address)
//   branch_offset   16-bit signed word offset, relative to pc+PC_STEP
//   reg_address     register-indirect target
//   clr_err         clears sticky error flags (works even with en low)
//   pc              registered program counter
//   stack_empty/full, ovf_err, unf_err   stack status and sticky errors
// Configuration macro UNIDADE_PC_PILHA_TRAP_EN: when defined, stack
// overflow/underflow redirect pc to TRAP_VECTOR and a full push is dropped.
// ---------------------------------------------------------------------------
module unidade_pc_pilha
    import unidade_pc_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter int              STACK_DEPTH = 8,
    parameter int              PC_STEP     = 1,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        pc_control,
    input  logic [JUMP_W-1:0] jump_address,
    input  logic [15:0]       branch_offset,
    input  logic [ADDR_W-1:0] reg_address,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] pc,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              ovf_err,
    output logic              unf_err
);

    localparam int CNT_W = $clog2(STACK_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_seq, jump_target, branch_ext, pc_next, stack_top;
    logic [CNT_W-1:0]  count;
    logic              do_call, do_ret, push, ovf_set, unf_set;

    assign pc_seq  = pc + ADDR_W'(PC_STEP);
    assign do_call = en && (pc_control == PC_CALL);
    assign do_ret  = en && (pc_control == PC_RET);
    assign ovf_set = do_call && stack_full;
    assign unf_set = do_ret && stack_empty;

    assign stack_empty = (count == '0);
    assign stack_full  = (count == CNT_W'(STACK_DEPTH));

    // Jump keeps the upper region bits of pc_seq and replaces the low 28.
    always_comb begin
        jump_target       = pc_seq;
        jump_target[27:0] = {jump_address, 2'b00};
    end

    assign branch_ext = {{(ADDR_W-18){branch_offset[15]}}, branch_offset, 2'b00};

`ifdef UNIDADE_PC_PILHA_TRAP_EN
    assign push = do_call && !stack_full;
`else
    assign push = do_call;
    // TRAP_VECTOR has no consumer in this build; fold it away explicitly.
    logic unused_trap;
    assign unused_trap = ^TRAP_VECTOR;
`endif

    // NOTE: pc_next gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        pc_next = pc_seq;
        case (pc_control)
            PC_JUMP:   pc_next = jump_target;
            PC_REG:    pc_next = reg_address;
            PC_BRANCH: pc_next = pc_seq + branch_ext;
            PC_CALL: begin
                pc_next = jump_target;
`ifdef UNIDADE_PC_PILHA_TRAP_EN
                if (stack_full) pc_next = TRAP_VECTOR;
`endif
            end
            PC_RET: begin
`ifdef UNIDADE_PC_PILHA_TRAP_EN
                pc_next = stack_empty ? TRAP_VECTOR : stack_top;
`else
                pc_next = stack_empty ? pc_seq : stack_top;
`endif
            end
            PC_HOLD:   pc_next = pc;
            default:   pc_next = pc_seq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (en)
                pc <= pc_next;
            // A new error in the same cycle as clr_err wins over the clear.
            ovf_err <= ovf_set | (ovf_err & ~clr_err);
            unf_err <= unf_set | (unf_err & ~clr_err);
        end
    end

    pilha_retorno #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_pilha (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (do_ret),
        .din   (pc_seq),
        .dout  (stack_top),
        .count (count)
    );

endmodule
